// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters; define BP_STATS_EN for branch/mispredict counters
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PC,
  output logic                  predict_taken,
  output logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_PC,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target
`ifdef BP_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][DATA_WIDTH-1:0] tgt_q, tgt_d;
  logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
  logic [IDX_W-1:0] idx, u_idx;
  logic [TAG_W-1:0] tag, u_tag;
  logic [1:0] u_ctr;
  logic u_hit, u_pred, unused_lo;
  assign idx = PC[IDX_W+1:2];
  assign tag = PC[DATA_WIDTH-1:IDX_W+2];
  assign u_idx = upd_PC[IDX_W+1:2];
  assign u_tag = upd_PC[DATA_WIDTH-1:IDX_W+2];
  assign unused_lo = ^{PC[1:0], upd_PC[1:0]};
  assign predict_taken = valid_q[idx] && tag_q[idx] == tag && ctr_q[idx][1];
  assign branch_target = predict_taken ? tgt_q[idx] : '0;
  assign u_ctr = ctr_q[u_idx];
  assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
  assign u_pred = u_hit && u_ctr[1];
  // a hit trains the entry in place; a taken miss evicts and allocates weakly-taken
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    ctr_d = ctr_q;
    if (upd_valid && (u_hit || upd_taken)) begin
      valid_d[u_idx] = 1'b1;
      tag_d[u_idx] = u_tag;
      tgt_d[u_idx] = upd_taken ? upd_target : tgt_q[u_idx];
      ctr_d[u_idx] = !u_hit ? 2'b10 :
                     upd_taken ? (&u_ctr ? u_ctr : u_ctr + 2'd1) :
                     (|u_ctr ? u_ctr - 2'd1 : u_ctr);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      ctr_q <= {ENTRIES{2'b01}};
    end else begin
      valid_q <= valid_d;
      ctr_q <= ctr_d;
    end
  end
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end
`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d, stat_mispredicts_q, stat_mispredicts_d;
  logic mispredict;
  assign mispredict = (u_pred != upd_taken) || (u_pred && upd_taken && tgt_q[u_idx] != upd_target);
  always_comb begin
    stat_branches_d = stat_clr ? '0 : upd_valid ? stat_branches_q + 32'd1 : stat_branches_q;
    stat_mispredicts_d = stat_clr ? '0 : (upd_valid && mispredict) ? stat_mispredicts_q + 32'd1 : stat_mispredicts_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_branches_q <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end
  assign stat_branches = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor (stats checks under BP_STATS_EN)
module tb_branch_predictor;
  logic clk, rst, predict_taken, upd_valid, upd_taken;
  logic [31:0] PC, branch_target, upd_PC, upd_target;
  int checks = 0, errors = 0;
`ifdef BP_STATS_EN
  logic stat_clr;
  logic [31:0] stat_branches, stat_mispredicts;
`endif
  branch_predictor dut (
    .clk(clk), .rst(rst), .PC(PC), .predict_taken(predict_taken), .branch_target(branch_target),
    .upd_valid(upd_valid), .upd_PC(upd_PC), .upd_taken(upd_taken), .upd_target(upd_target)
`ifdef BP_STATS_EN
    , .stat_clr(stat_clr), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] bt);
    PC = pc;
    #1;
    chk({tag, "_pt"}, {31'd0, predict_taken}, {31'd0, pt});
    chk({tag, "_bt"}, branch_target, bt);
  endtask
  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    upd_valid = 1;
    upd_PC = pc;
    upd_taken = t;
    upd_target = tg;
    @(posedge clk);
    #1;
    upd_valid = 0;
  endtask
  task automatic stats(input string tag, input logic [31:0] br, input logic [31:0] mis);
`ifdef BP_STATS_EN
    #1;
    chk({tag, "_br"}, stat_branches, br);
    chk({tag, "_mis"}, stat_mispredicts, mis);
`endif
  endtask
  initial begin
    rst = 0; upd_valid = 0; upd_PC = 0; upd_taken = 0; upd_target = 0; PC = 0;
`ifdef BP_STATS_EN
    stat_clr = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    look("rst40", 32'h40, 0, 0);
    look("rst0", 32'h0, 0, 0);
    stats("rst", 0, 0);
    upd(32'h40, 1, 32'h100);
    look("alloc", 32'h40, 1, 32'h100);
    look("alloc_lo", 32'h42, 1, 32'h100);
    look("alias80", 32'h80, 0, 0);
    look("idx1", 32'h44, 0, 0);
    stats("alloc", 1, 1);
    upd(32'h40, 0, 32'h0);
    look("h01", 32'h40, 0, 0);
    upd(32'h40, 1, 32'h100);
    look("h10", 32'h40, 1, 32'h100);
    upd(32'h40, 1, 32'h100);
    look("h11", 32'h40, 1, 32'h100);
    upd(32'h40, 1, 32'h100);
    look("hsat", 32'h40, 1, 32'h100);
    upd(32'h40, 0, 32'h0);
    look("h11to10", 32'h40, 1, 32'h100);
    upd(32'h40, 1, 32'h104);
    look("newtgt", 32'h40, 1, 32'h104);
    upd(32'h40, 0, 32'h0);
    look("back10", 32'h40, 1, 32'h104);
    stats("hyst", 8, 6);
    upd(32'h200, 0, 32'h0);
    look("ntmiss", 32'h200, 0, 0);
    look("ntkeep", 32'h40, 1, 32'h104);
    stats("ntmiss", 9, 6);
    PC = 32'h40; upd_valid = 1; upd_PC = 32'h40; upd_taken = 0; upd_target = 0;
    #1;
    chk("coll_pre", {31'd0, predict_taken}, 32'd1);
    @(posedge clk);
    #1;
    upd_valid = 0;
    look("coll_post", 32'h40, 0, 0);
    stats("coll", 10, 7);
    upd(32'h40, 1, 32'h300);
    look("retrain", 32'h40, 1, 32'h300);
    rst = 0; upd_valid = 1; upd_PC = 32'h80; upd_taken = 1; upd_target = 32'h500;
    @(posedge clk);
    #1;
    rst = 1; upd_valid = 0;
    look("rstupd80", 32'h80, 0, 0);
    look("rstupd40", 32'h40, 0, 0);
    stats("rstupd", 0, 0);
    upd(32'h40, 1, 32'h100);
    upd(32'h40, 1, 32'h100);
    upd(32'h200, 0, 32'h0);
    look("s3", 32'h40, 1, 32'h100);
    stats("s3", 3, 1);
`ifdef BP_STATS_EN
    stat_clr = 1;
    upd_valid = 1; upd_PC = 32'h40; upd_taken = 0;
    @(posedge clk);
    #1;
    stat_clr = 0; upd_valid = 0;
    stats("clr", 0, 0);
    look("clr_ctr", 32'h40, 1, 32'h100);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
